mem1_scrub_arb: RTL

Controller that sits in front of the 8-entry parity-protected lookup ROM. The ROM has a combinational 3-bit index, 8-bit data and a 1-bit even-parity output.
- Shares the single ROM index port between a host read port and a background scrubber.
- The scrubber walks every entry, checks parity, and reports the error count and the first failing index.
- Host reads have priority and may pre-empt a scrub between entries.

---
 rtl/mem1_pkg.sv | 27 ++
 rtl/mem1_scrub_arb_if.sv | 52 +++++
 rtl/mem1_parity_chk.sv | 20 ++
 rtl/mem1_scrub_arb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem1_pkg.sv
// Shared types and helpers for the parity-scrubbing ROM arbiter.
package mem1_pkg;

    // Default geometry of the lookup ROM: 8 entries of 8 bits.
    localparam int IDX_W_DEF  = 3;
    localparam int DATA_W_DEF = 8;

    // Widest data word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W  = 64;

    // Arbiter states. Host reads interleave with the two-phase scrub walk.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOST_RD    = 3'd1,
        ST_HOST_ACK   = 3'd2,
        ST_SCRUB_ADDR = 3'd3,
        ST_SCRUB_CHK  = 3'd4
    } state_e;

    // Even parity over {data, parity}: an odd number of ones is an error.
    function automatic logic even_parity_err(input logic [PAR_MAX_W-1:0] data,
                                             input logic                 parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/mem1_scrub_arb_if.sv
// Bundle of ROM, host-read and scrub-control signals around the arbiter.
//
// Handshakes:
//   host: the requester raises host_req with host_idx and holds both stable
//         until it sees host_ack; host_ack is a one-cycle pulse and
//         host_data/host_perr are valid in that cycle. Dropping host_req in
//         the ack cycle is allowed and does not start a second read.
//   scrub: scrub_start is a one-cycle pulse; it is accepted only while
//         scrub_busy is low. scrub_busy stays high until the cycle in which
//         scrub_done pulses; err_count/first_err_idx are stable from then on.
interface mem1_scrub_arb_if import mem1_pkg::*; #(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [IDX_W-1:0]  mem_index;
    logic [DATA_W-1:0] mem_data;
    logic              mem_parity;

    logic              host_req;
    logic [IDX_W-1:0]  host_idx;
    logic              host_ack;
    logic [DATA_W-1:0] host_data;
    logic              host_perr;

    logic              scrub_start;
    logic              scrub_busy;
    logic              scrub_done;
    logic [IDX_W:0]    err_count;
    logic [IDX_W-1:0]  first_err_idx;

    // Arbiter side.
    modport slave (
        output mem_index,
        input  mem_data, mem_parity,
        input  host_req, host_idx,
        output host_ack, host_data, host_perr,
        input  scrub_start,
        output scrub_busy, scrub_done, err_count, first_err_idx
    );

    // Environment side: ROM plus host and scrub controllers.
    modport master (
        input  mem_index,
        output mem_data, mem_parity,
        output host_req, host_idx,
        input  host_ack, host_data, host_perr,
        output scrub_start,
        input  scrub_busy, scrub_done, err_count, first_err_idx
    );

endinterface

// File: rtl/mem1_parity_chk.sv
// Combinational even-parity checker shared by the host and scrub paths.
module mem1_parity_chk import mem1_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              parity_i,
    output logic              err_o
);

    logic [PAR_MAX_W-1:0] data_ext;

    // Zero-extend to the helper's fixed width; extra zeros do not alter parity.
    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = data_i;
    end

    assign err_o = even_parity_err(data_ext, parity_i);

endmodule

// File: rtl/mem1_scrub_arb.sv
// Arbiter sharing one ROM index port between host reads and a parity scrubber.
// Host reads win whenever the scrubber is between entries; a suspended scrub
// resumes at the entry it was about to address.
module mem1_scrub_arb import mem1_pkg::*; #(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem1_scrub_arb_if.slave  bus,
    output state_e           dbg_state_o
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            state_q,     state_d;
    logic [IDX_W-1:0]  mem_index_q, mem_index_d;
    logic [DATA_W-1:0] host_data_q, host_data_d;
    logic              host_perr_q, host_perr_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [IDX_W:0]    err_cnt_q,   err_cnt_d;
    logic [IDX_W-1:0]  first_err_q, first_err_d;
    logic [IDX_W-1:0]  scan_ptr_q,  scan_ptr_d;
    logic              pend_q,      pend_d;

    logic              par_err;
    logic              start_acc;

    // One checker observes whatever entry mem_index currently selects.
    mem1_parity_chk #(.DATA_W(DATA_W)) u_par (
        .data_i   (bus.mem_data),
        .parity_i (bus.mem_parity),
        .err_o    (par_err)
    );

    // A start pulse only counts while no scrub is running or queued.
    assign start_acc = bus.scrub_start && !busy_q;

    // State register and all datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_index_q <= '0;
            host_data_q <= '0;
            host_perr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            scan_ptr_q  <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_index_q <= mem_index_d;
            host_data_q <= host_data_d;
            host_perr_q <= host_perr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            scan_ptr_q  <= scan_ptr_d;
            pend_q      <= pend_d;
        end
    end

    // Next-state and register updates; everything holds unless a state moves it.
    always_comb begin
        state_d     = state_q;
        mem_index_d = mem_index_q;
        host_data_d = host_data_q;
        host_perr_d = host_perr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        scan_ptr_d  = scan_ptr_q;
        pend_d      = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.host_req) begin
                    state_d     = ST_HOST_RD;
                    mem_index_d = bus.host_idx;
                    // Start arriving with a host read is queued behind it.
                    if (start_acc) begin
                        pend_d = 1'b1;
                        busy_d = 1'b1;
                    end
                end else if (start_acc || pend_q) begin
                    state_d     = ST_SCRUB_ADDR;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    scan_ptr_d  = '0;
                    busy_d      = 1'b1;
                    pend_d      = 1'b0;
                end
            end

            ST_HOST_RD: begin
                host_data_d = bus.mem_data;
                host_perr_d = par_err;
                state_d     = ST_HOST_ACK;
                if (start_acc) begin
                    pend_d = 1'b1;
                    busy_d = 1'b1;
                end
            end

            ST_HOST_ACK: begin
                // host_req is deliberately not looked at here: the requester
                // may still be holding it during the ack cycle.
                if (start_acc || pend_q) begin
                    state_d     = ST_SCRUB_ADDR;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    scan_ptr_d  = '0;
                    busy_d      = 1'b1;
                    pend_d      = 1'b0;
                end else if (busy_q) begin
                    state_d = ST_SCRUB_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCRUB_ADDR: begin
                if (bus.host_req) begin
                    state_d     = ST_HOST_RD;
                    mem_index_d = bus.host_idx;
                end else begin
                    state_d     = ST_SCRUB_CHK;
                    mem_index_d = scan_ptr_q;
                end
            end

            ST_SCRUB_CHK: begin
                if (par_err) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == '0) begin
                        first_err_d = scan_ptr_q;
                    end
                end
                if (scan_ptr_q == LAST_IDX) begin
                    // Last entry checked: pointer stays put, no wrap-around.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    scan_ptr_d = scan_ptr_q + 1'b1;
                    state_d    = ST_SCRUB_ADDR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_index     = mem_index_q;
    assign bus.host_ack      = (state_q == ST_HOST_ACK);
    assign bus.host_data     = host_data_q;
    assign bus.host_perr     = host_perr_q;
    assign bus.scrub_busy    = busy_q;
    assign bus.scrub_done    = done_q;
    assign bus.err_count     = err_cnt_q;
    assign bus.first_err_idx = first_err_q;
    assign dbg_state_o       = state_q;

endmodule
